// File: rtl/rv_pkg.sv
// Shared RV32 decode definitions: opcodes, funct3 codes, ALU encodings,
// immediate formats, the decoded-control bundle and the immediate generator.
package rv_pkg;

    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_MISCMEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SR      = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_PRIV    = 3'b000;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_fmt_e;

    typedef struct packed {
        alu_op_e  alu_op;
        logic     a_sel;
        logic     b_sel;
        logic     reg_we;
        logic     mem_we;
        logic     mem_re;
        logic     csr;
        logic     csr_imm;
        logic     rs1_used;
        logic     rs2_used;
        logic     illegal;
        imm_fmt_e imm_fmt;
    } ctrl_t;

    function automatic logic [31:0] imm_gen(input logic [31:0] ins, input imm_fmt_e fmt);
        logic [31:0] imm;
        imm = '0;
        case (fmt)
            IMM_I:   imm = {{20{ins[31]}}, ins[31:20]};
            IMM_S:   imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            IMM_B:   imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            IMM_U:   imm = {ins[31:12], 12'b0};
            IMM_J:   imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/rv_regfile.sv
// Architectural register file: two asynchronous read ports, one synchronous
// write port; x0 and indices beyond NREGS read as zero and are never written.
module rv_regfile
    import rv_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int XLEN  = 32
) (
    input  logic            i_clk,
    input  logic [4:0]      i_ra1,
    input  logic [4:0]      i_ra2,
    output logic [XLEN-1:0] o_rd1,
    output logic [XLEN-1:0] o_rd2,
    input  logic            i_we,
    input  logic [4:0]      i_wa,
    input  logic [XLEN-1:0] i_wd
);

    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0] r_mem [NREGS];
    logic            w_wr_ok;
    logic            w_rd1_ok;
    logic            w_rd2_ok;

    assign w_wr_ok  = i_we && (i_wa != 5'd0) && (32'(i_wa) < NREGS);
    assign w_rd1_ok = (i_ra1 != 5'd0) && (32'(i_ra1) < NREGS);
    assign w_rd2_ok = (i_ra2 != 5'd0) && (32'(i_ra2) < NREGS);

    always_ff @(posedge i_clk) begin
        if (w_wr_ok) begin
            r_mem[i_wa[AW-1:0]] <= i_wd;
        end
    end

    assign o_rd1 = w_rd1_ok ? r_mem[i_ra1[AW-1:0]] : '0;
    assign o_rd2 = w_rd2_ok ? r_mem[i_ra2[AW-1:0]] : '0;

endmodule

// File: rtl/decode_read_stage.sv
// RV32 decode / register-read stage: decodes one instruction per cycle, reads
// operands with EX bypass and writeback write-through, and stalls on load-use.
module decode_read_stage
    import rv_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int NREGS     = 32,
    parameter int BYPASS_EN = 1,
    parameter int CSR_EN    = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [31:0]     in_instr,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_rs1_val,
    output logic [XLEN-1:0] out_rs2_val,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [XLEN-1:0] out_imm,
    output logic [3:0]      out_alu_op,
    output logic            out_a_sel,
    output logic            out_b_sel,
    output logic            out_reg_we,
    output logic            out_mem_we,
    output logic            out_mem_re,
    output logic [2:0]      out_funct3,
    output logic            out_csr,
    output logic            out_csr_imm,
    output logic            out_illegal,
    input  logic            wb_we,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            ex_valid,
    input  logic [4:0]      ex_rd,
    input  logic            ex_reg_we,
    input  logic            ex_is_load,
    input  logic [XLEN-1:0] ex_data
);

    function automatic alu_op_e alu_sel(input logic [2:0] f3, input logic alt, input logic is_op);
        alu_op_e op;
        op = ALU_ADD;
        case (f3)
            F3_ADD_SUB: op = (alt && is_op) ? ALU_SUB : ALU_ADD;
            F3_SLL:     op = ALU_SLL;
            F3_SLT:     op = ALU_SLT;
            F3_SLTU:    op = ALU_SLTU;
            F3_XOR:     op = ALU_XOR;
            F3_SR:      op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:      op = ALU_OR;
            F3_AND:     op = ALU_AND;
            default:    op = ALU_ADD;
        endcase
        return op;
    endfunction

    function automatic logic [XLEN-1:0] fwd(
        input logic [4:0]      idx,
        input logic [XLEN-1:0] rf_val,
        input logic            ex_ok,
        input logic [4:0]      exrd,
        input logic [XLEN-1:0] exdat,
        input logic            wbwe,
        input logic [4:0]      wbaddr,
        input logic [XLEN-1:0] wbdat
    );
        logic [XLEN-1:0] v;
        if (idx == 5'd0) begin
            v = '0;
        end else if (ex_ok && (exrd == idx)) begin
            v = exdat;
        end else if (wbwe && (wbaddr == idx)) begin
            v = wbdat;
        end else begin
            v = rf_val;
        end
        return v;
    endfunction

    // ---- p0: decode, operand read, hazard detection ----
    logic [6:0]      w_opc_p0;
    logic [4:0]      w_rd_p0;
    logic [4:0]      w_rs1_p0;
    logic [4:0]      w_rs2_p0;
    logic [2:0]      w_f3_p0;
    ctrl_t           w_ctl_p0;
    logic [XLEN-1:0] w_imm_p0;
    logic [XLEN-1:0] w_rf1_p0;
    logic [XLEN-1:0] w_rf2_p0;
    logic [XLEN-1:0] w_rs1_val_p0;
    logic [XLEN-1:0] w_rs2_val_p0;
    logic            w_ex_fwd;
    logic            w_hz;
    logic            w_adv;
    logic            w_take;
    logic            w_wb_ok;

    logic            r_vld_p1;
    logic [XLEN-1:0] r_pc_p1;
    logic [XLEN-1:0] r_rs1_val_p1;
    logic [XLEN-1:0] r_rs2_val_p1;
    logic [4:0]      r_rd_p1;
    logic [4:0]      r_rs1_p1;
    logic [4:0]      r_rs2_p1;
    logic [XLEN-1:0] r_imm_p1;
    logic [3:0]      r_alu_op_p1;
    logic            r_a_sel_p1;
    logic            r_b_sel_p1;
    logic            r_reg_we_p1;
    logic            r_mem_we_p1;
    logic            r_mem_re_p1;
    logic [2:0]      r_funct3_p1;
    logic            r_csr_p1;
    logic            r_csr_imm_p1;
    logic            r_illegal_p1;

    assign w_opc_p0 = in_instr[6:0];
    assign w_rd_p0  = in_instr[11:7];
    assign w_f3_p0  = in_instr[14:12];
    assign w_rs1_p0 = in_instr[19:15];
    assign w_rs2_p0 = in_instr[24:20];

    always_comb begin
        w_ctl_p0         = '0;
        w_ctl_p0.alu_op  = ALU_ADD;
        w_ctl_p0.b_sel   = 1'b1;
        w_ctl_p0.imm_fmt = IMM_NONE;
        case (w_opc_p0)
            OPC_LUI: begin
                w_ctl_p0.imm_fmt = IMM_U;
                w_ctl_p0.reg_we  = 1'b1;
                w_ctl_p0.alu_op  = ALU_PASSB;
            end
            OPC_AUIPC, OPC_JAL: begin
                w_ctl_p0.imm_fmt = (w_opc_p0 == OPC_JAL) ? IMM_J : IMM_U;
                w_ctl_p0.reg_we  = 1'b1;
                w_ctl_p0.a_sel   = 1'b1;
            end
            OPC_JALR: begin
                w_ctl_p0.imm_fmt  = IMM_I;
                w_ctl_p0.reg_we   = 1'b1;
                w_ctl_p0.rs1_used = 1'b1;
            end
            OPC_BRANCH: begin
                w_ctl_p0.imm_fmt  = IMM_B;
                w_ctl_p0.a_sel    = 1'b1;
                w_ctl_p0.rs1_used = 1'b1;
                w_ctl_p0.rs2_used = 1'b1;
            end
            OPC_LOAD: begin
                w_ctl_p0.imm_fmt  = IMM_I;
                w_ctl_p0.reg_we   = 1'b1;
                w_ctl_p0.mem_re   = 1'b1;
                w_ctl_p0.rs1_used = 1'b1;
            end
            OPC_STORE: begin
                w_ctl_p0.imm_fmt  = IMM_S;
                w_ctl_p0.mem_we   = 1'b1;
                w_ctl_p0.rs1_used = 1'b1;
                w_ctl_p0.rs2_used = 1'b1;
            end
            OPC_OPIMM: begin
                w_ctl_p0.imm_fmt  = IMM_I;
                w_ctl_p0.reg_we   = 1'b1;
                w_ctl_p0.rs1_used = 1'b1;
                w_ctl_p0.alu_op   = alu_sel(w_f3_p0, in_instr[30], 1'b0);
            end
            OPC_OP: begin
                w_ctl_p0.b_sel    = 1'b0;
                w_ctl_p0.reg_we   = 1'b1;
                w_ctl_p0.rs1_used = 1'b1;
                w_ctl_p0.rs2_used = 1'b1;
                w_ctl_p0.alu_op   = alu_sel(w_f3_p0, in_instr[30], 1'b1);
            end
            OPC_MISCMEM: begin
                w_ctl_p0.imm_fmt = IMM_I;
            end
            OPC_SYSTEM: begin
                // funct3 == 0 is ECALL/EBREAK/xRET; anything else is a CSR access
                w_ctl_p0.imm_fmt = IMM_I;
                if (w_f3_p0 != F3_PRIV) begin
                    w_ctl_p0.csr      = 1'b1;
                    w_ctl_p0.csr_imm  = w_f3_p0[2];
                    w_ctl_p0.rs1_used = !w_f3_p0[2];
                    w_ctl_p0.reg_we   = 1'b1;
                    w_ctl_p0.alu_op   = ALU_PASSB;
                    w_ctl_p0.illegal  = (CSR_EN == 0);
                end
            end
            default: begin
                w_ctl_p0.illegal = 1'b1;
            end
        endcase
        if ((w_ctl_p0.rs1_used && (32'(w_rs1_p0) >= NREGS)) ||
            (w_ctl_p0.rs2_used && (32'(w_rs2_p0) >= NREGS)) ||
            (w_ctl_p0.reg_we   && (32'(w_rd_p0)  >= NREGS))) begin
            w_ctl_p0.illegal = 1'b1;
        end
        if (w_rd_p0 == 5'd0) begin
            w_ctl_p0.reg_we = 1'b0;
        end
    end

    assign w_imm_p0 = imm_gen(in_instr, w_ctl_p0.imm_fmt);

    rv_regfile #(
        .NREGS (NREGS),
        .XLEN  (XLEN)
    ) u_rf (
        .i_clk (clk),
        .i_ra1 (w_rs1_p0),
        .i_ra2 (w_rs2_p0),
        .o_rd1 (w_rf1_p0),
        .o_rd2 (w_rf2_p0),
        .i_we  (wb_we),
        .i_wa  (wb_addr),
        .i_wd  (wb_data)
    );

    assign w_ex_fwd     = ex_valid && ex_reg_we && !ex_is_load && (BYPASS_EN != 0);
    assign w_rs1_val_p0 = fwd(w_rs1_p0, w_rf1_p0, w_ex_fwd, ex_rd, ex_data, wb_we, wb_addr, wb_data);
    assign w_rs2_val_p0 = fwd(w_rs2_p0, w_rf2_p0, w_ex_fwd, ex_rd, ex_data, wb_we, wb_addr, wb_data);

    // Without bypass every EX-produced operand must wait, not only loads.
    assign w_hz = ex_valid && ex_reg_we && (ex_rd != 5'd0) &&
                  ((w_ctl_p0.rs1_used && (ex_rd == w_rs1_p0)) ||
                   (w_ctl_p0.rs2_used && (ex_rd == w_rs2_p0))) &&
                  (ex_is_load || (BYPASS_EN == 0));

    assign w_adv    = !r_vld_p1 || out_ready;
    assign in_ready = w_adv && !w_hz && !flush;
    assign w_take   = in_valid && !w_hz;
    assign w_wb_ok  = wb_we && (wb_addr != 5'd0) && (32'(wb_addr) < NREGS);

    // ---- p1: registered bundle toward execute ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p1     <= 1'b0;
            r_pc_p1      <= '0;
            r_rs1_val_p1 <= '0;
            r_rs2_val_p1 <= '0;
            r_rd_p1      <= '0;
            r_rs1_p1     <= '0;
            r_rs2_p1     <= '0;
            r_imm_p1     <= '0;
            r_alu_op_p1  <= '0;
            r_a_sel_p1   <= 1'b0;
            r_b_sel_p1   <= 1'b0;
            r_reg_we_p1  <= 1'b0;
            r_mem_we_p1  <= 1'b0;
            r_mem_re_p1  <= 1'b0;
            r_funct3_p1  <= '0;
            r_csr_p1     <= 1'b0;
            r_csr_imm_p1 <= 1'b0;
            r_illegal_p1 <= 1'b0;
        end else if (flush) begin
            r_vld_p1 <= 1'b0;
        end else if (w_adv) begin
            r_vld_p1 <= w_take;
            if (w_take) begin
                r_pc_p1      <= in_pc;
                r_rs1_val_p1 <= w_rs1_val_p0;
                r_rs2_val_p1 <= w_rs2_val_p0;
                r_rd_p1      <= w_rd_p0;
                r_rs1_p1     <= w_rs1_p0;
                r_rs2_p1     <= w_rs2_p0;
                r_imm_p1     <= w_imm_p0;
                r_alu_op_p1  <= w_ctl_p0.alu_op;
                r_a_sel_p1   <= w_ctl_p0.a_sel;
                r_b_sel_p1   <= w_ctl_p0.b_sel;
                r_reg_we_p1  <= w_ctl_p0.reg_we && !w_ctl_p0.illegal;
                r_mem_we_p1  <= w_ctl_p0.mem_we && !w_ctl_p0.illegal;
                r_mem_re_p1  <= w_ctl_p0.mem_re && !w_ctl_p0.illegal;
                r_funct3_p1  <= w_f3_p0;
                r_csr_p1     <= w_ctl_p0.csr;
                r_csr_imm_p1 <= w_ctl_p0.csr_imm;
                r_illegal_p1 <= w_ctl_p0.illegal;
            end
        end else begin
            // Held bundle: pick up writebacks so operands never go stale.
            if (w_wb_ok && (wb_addr == r_rs1_p1)) begin
                r_rs1_val_p1 <= wb_data;
            end
            if (w_wb_ok && (wb_addr == r_rs2_p1)) begin
                r_rs2_val_p1 <= wb_data;
            end
        end
    end

    assign out_valid   = r_vld_p1;
    assign out_pc      = r_pc_p1;
    assign out_rs1_val = r_rs1_val_p1;
    assign out_rs2_val = r_rs2_val_p1;
    assign out_rd      = r_rd_p1;
    assign out_rs1     = r_rs1_p1;
    assign out_rs2     = r_rs2_p1;
    assign out_imm     = r_imm_p1;
    assign out_alu_op  = r_alu_op_p1;
    assign out_a_sel   = r_a_sel_p1;
    assign out_b_sel   = r_b_sel_p1;
    assign out_reg_we  = r_reg_we_p1;
    assign out_mem_we  = r_mem_we_p1;
    assign out_mem_re  = r_mem_re_p1;
    assign out_funct3  = r_funct3_p1;
    assign out_csr     = r_csr_p1;
    assign out_csr_imm = r_csr_imm_p1;
    assign out_illegal = r_illegal_p1;

endmodule

// File: tb/tb_decode_read_stage.sv
// Scoreboard bench for decode_read_stage: a default instance plus an RV32E
// instance without bypass and without CSR support.
module tb_decode_read_stage;
    import rv_pkg::*;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [3:0]  alu;
        logic        a, b, we, mw, mr, cs, il;
        logic        c1, c2, ci, ca;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    logic wb_we = 1'b0;
    logic [4:0] wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic ex_valid = 1'b0, ex_reg_we = 1'b0, ex_is_load = 1'b0;
    logic [4:0] ex_rd = '0;
    logic [31:0] ex_data = '0;

    logic iv0 = 1'b0, iv1 = 1'b0, ordy0 = 1'b1, ordy1 = 1'b1;
    logic [31:0] ipc0 = '0, ipc1 = '0, iins0 = '0, iins1 = '0;
    logic ir0, ir1, ov0, ov1;
    logic [31:0] opc0, opc1, or1_0, or1_1, or2_0, or2_1, oimm0, oimm1;
    logic [4:0] ord0, ord1, ors1_0, ors1_1, ors2_0, ors2_1;
    logic [3:0] oalu0, oalu1;
    logic oa0, oa1, ob0, ob1, owe0, owe1, omw0, omw1, omr0, omr1;
    logic [2:0] of3_0, of3_1;
    logic ocs0, ocs1, oci0, oci1, oil0, oil1;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    decode_read_stage u0 (
        .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .in_pc(ipc0), .in_instr(iins0),
        .flush(flush), .out_valid(ov0), .out_ready(ordy0), .out_pc(opc0),
        .out_rs1_val(or1_0), .out_rs2_val(or2_0), .out_rd(ord0), .out_rs1(ors1_0), .out_rs2(ors2_0),
        .out_imm(oimm0), .out_alu_op(oalu0), .out_a_sel(oa0), .out_b_sel(ob0),
        .out_reg_we(owe0), .out_mem_we(omw0), .out_mem_re(omr0), .out_funct3(of3_0),
        .out_csr(ocs0), .out_csr_imm(oci0), .out_illegal(oil0),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_reg_we(ex_reg_we), .ex_is_load(ex_is_load), .ex_data(ex_data)
    );

    decode_read_stage #(.XLEN(32), .NREGS(16), .BYPASS_EN(0), .CSR_EN(0)) u1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .in_pc(ipc1), .in_instr(iins1),
        .flush(flush), .out_valid(ov1), .out_ready(ordy1), .out_pc(opc1),
        .out_rs1_val(or1_1), .out_rs2_val(or2_1), .out_rd(ord1), .out_rs1(ors1_1), .out_rs2(ors2_1),
        .out_imm(oimm1), .out_alu_op(oalu1), .out_a_sel(oa1), .out_b_sel(ob1),
        .out_reg_we(owe1), .out_mem_we(omw1), .out_mem_re(omr1), .out_funct3(of3_1),
        .out_csr(ocs1), .out_csr_imm(oci1), .out_illegal(oil1),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_reg_we(ex_reg_we), .ex_is_load(ex_is_load), .ex_data(ex_data)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] pc, r1, r2, imm, input logic [4:0] rd,
                                input logic [3:0] alu, input logic a, b, we, mw, mr, cs, il,
                                input logic c1, c2, ci, ca);
        exp_t e;
        e.pc = pc; e.r1 = r1; e.r2 = r2; e.imm = imm; e.rd = rd; e.alu = alu;
        e.a = a; e.b = b; e.we = we; e.mw = mw; e.mr = mr; e.cs = cs; e.il = il;
        e.c1 = c1; e.c2 = c2; e.ci = ci; e.ca = ca;
        return e;
    endfunction

    task automatic cmp_bundle(input string tag, input exp_t e, input logic [31:0] pc, r1, r2, imm,
                              input logic [4:0] rd, input logic [3:0] alu,
                              input logic a, b, we, mw, mr, cs, il);
        chk({tag, "_pc"}, pc, e.pc);
        chk({tag, "_ctl"}, 32'({we, mw, mr, cs, il}), 32'({e.we, e.mw, e.mr, e.cs, e.il}));
        if (e.c1) chk({tag, "_rs1_val"}, r1, e.r1);
        if (e.c2) chk({tag, "_rs2_val"}, r2, e.r2);
        if (e.ci) chk({tag, "_imm"}, imm, e.imm);
        if (e.ca) chk({tag, "_rd_alu_sel"}, 32'({rd, alu, a, b}), 32'({e.rd, e.alu, e.a, e.b}));
    endtask

    always @(negedge clk) begin
        if (!rst && ov0 && ordy0) begin
            if (q0.size() == 0) begin
                chk("u0_unexpected_bundle_pc", opc0, 32'hFFFF_FFFF);
            end else begin
                e0 = q0.pop_front();
                cmp_bundle($sformatf("u0_pc%0h", e0.pc), e0, opc0, or1_0, or2_0, oimm0, ord0, oalu0,
                           oa0, ob0, owe0, omw0, omr0, ocs0, oil0);
            end
        end
        if (!rst && ov1 && ordy1) begin
            if (q1.size() == 0) begin
                chk("u1_unexpected_bundle_pc", opc1, 32'hFFFF_FFFF);
            end else begin
                e1 = q1.pop_front();
                cmp_bundle($sformatf("u1_pc%0h", e1.pc), e1, opc1, or1_1, or2_1, oimm1, ord1, oalu1,
                           oa1, ob1, owe1, omw1, omr1, ocs1, oil1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an instruction until accepted; the expectation is queued at acceptance.
    task automatic send(input bit which, input logic [31:0] pc, input logic [31:0] ins,
                        input bit push, input exp_t e);
        bit done;
        done = 1'b0;
        if (which) begin iv1 = 1'b1; ipc1 = pc; iins1 = ins; end
        else       begin iv0 = 1'b1; ipc0 = pc; iins0 = ins; end
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            if ((which ? ir1 : ir0) === 1'b1) begin
                done = 1'b1;
                if (push) begin
                    if (which) q1.push_back(e); else q0.push_back(e);
                end
            end
            tick();
        end
        if (!done) chk($sformatf("accept_timeout_pc%0h", pc), 32'd0, 32'd1);
        if (which) iv1 = 1'b0; else iv0 = 1'b0;
    endtask

    initial begin
        exp_t none;
        none = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_u0_out_valid", 32'(ov0), 32'd0);
        chk("rst_u0_pc_imm", opc0 | oimm0, 32'd0);
        chk("rst_u0_ctl_idx", 32'({ord0, ors1_0, ors2_0, owe0, omw0, omr0, oil0, oalu0}), 32'd0);
        chk("rst_u1_out_valid", 32'(ov1), 32'd0);
        tick();
        rst = 1'b0;

        wb_we = 1'b1; wb_addr = 5'd1; wb_data = 32'h11;
        tick();
        wb_addr = 5'd2; wb_data = 32'h22;
        tick();
        wb_we = 1'b0;

        // addi x1,x0,5
        send(0, 32'h100, 32'h0050_0093, 1,
             mk(32'h100, 32'h0, 32'h0, 32'h5, 5'd1, ALU_ADD, 0, 1, 1, 0, 0, 0, 0, 1, 0, 1, 1));
        // add x4,x3,x3 with x3 written in the same cycle
        wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'hDEAD;
        send(0, 32'h104, 32'h0031_8233, 1,
             mk(32'h104, 32'hDEAD, 32'hDEAD, 32'h0, 5'd4, ALU_ADD, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 1));
        wb_we = 1'b0;

        // load-use: lw x5 in EX, add x6,x5,x1 in fetch
        ex_valid = 1'b1; ex_rd = 5'd5; ex_reg_we = 1'b1; ex_is_load = 1'b1; ex_data = 32'hBAD;
        iv0 = 1'b1; ipc0 = 32'h108; iins0 = 32'h0012_8333;
        @(negedge clk);
        chk("loaduse_in_ready", 32'(ir0), 32'd0);
        tick();
        ex_is_load = 1'b0; ex_data = 32'h7;
        @(negedge clk);
        chk("loaduse_bubble_valid", 32'(ov0), 32'd0);
        chk("loaduse_release_in_ready", 32'(ir0), 32'd1);
        if (ir0 === 1'b1)
            q0.push_back(mk(32'h108, 32'h7, 32'h11, 32'h0, 5'd6, ALU_ADD, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 1));
        tick();
        iv0 = 1'b0; ex_valid = 1'b0; ex_reg_we = 1'b0; ex_rd = 5'd0;

        // add x7,x1,x2 then hold it three cycles while x2 is rewritten
        send(0, 32'h10C, 32'h0020_83B3, 1,
             mk(32'h10C, 32'h11, 32'h55, 32'h0, 5'd7, ALU_ADD, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 1));
        ordy0 = 1'b0;
        iv0 = 1'b1; ipc0 = 32'h110; iins0 = 32'h1234_5437;
        for (int h = 0; h < 3; h++) begin
            @(negedge clk);
            chk($sformatf("hold%0d_valid", h), 32'(ov0), 32'd1);
            chk($sformatf("hold%0d_pc", h), opc0, 32'h10C);
            chk($sformatf("hold%0d_rs1_val", h), or1_0, 32'h11);
            chk($sformatf("hold%0d_rs2_val", h), or2_0, (h == 2) ? 32'h55 : 32'h22);
            chk($sformatf("hold%0d_rd_we", h), 32'({ord0, owe0, ob0}), 32'({5'd7, 1'b1, 1'b0}));
            chk($sformatf("hold%0d_in_ready", h), 32'(ir0), (h == 2) ? 32'd1 : 32'd0);
            if (h == 2) break;
            tick();
            if (h == 0) begin wb_we = 1'b1; wb_addr = 5'd2; wb_data = 32'h55; end
            if (h == 1) begin wb_we = 1'b0; ordy0 = 1'b1; end
        end
        tick();
        iv0 = 1'b0;
        // the lui waiting in fetch was accepted at the release edge
        q0.push_back(mk(32'h110, 32'h0, 32'h0, 32'h1234_5000, 5'd8, ALU_PASSB, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1));

        // flush kills the held jal and blocks the arriving sw
        send(0, 32'h114, 32'h0100_00EF, 0, none);
        ordy0 = 1'b0; flush = 1'b1;
        iv0 = 1'b1; ipc0 = 32'h118; iins0 = 32'hFE20_AE23;
        @(negedge clk);
        chk("flush_in_ready", 32'(ir0), 32'd0);
        chk("flush_held_valid", 32'(ov0), 32'd1);
        tick();
        flush = 1'b0; iv0 = 1'b0; ordy0 = 1'b1;
        @(negedge clk);
        chk("flush_out_valid", 32'(ov0), 32'd0);
        tick();

        // sw x2,-4(x1)
        send(0, 32'h118, 32'hFE20_AE23, 1,
             mk(32'h118, 32'h11, 32'h55, 32'hFFFF_FFFC, 5'd0, ALU_ADD, 0, 1, 0, 1, 0, 0, 0, 1, 1, 1, 0));
        // jal x1,16
        send(0, 32'h11C, 32'h0100_00EF, 1,
             mk(32'h11C, 32'h0, 32'h0, 32'h10, 5'd1, ALU_ADD, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1));
        // addi x0,x0,1 writes nothing
        send(0, 32'h120, 32'h0010_0013, 1,
             mk(32'h120, 32'h0, 32'h0, 32'h1, 5'd0, ALU_ADD, 0, 1, 0, 0, 0, 0, 0, 1, 0, 1, 1));
        // unknown opcode
        send(0, 32'h124, 32'h0000_007F, 1,
             mk(32'h124, 32'h0, 32'h0, 32'h0, 5'd0, ALU_ADD, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));

        // RV32E instance, no bypass: any EX producer stalls
        ex_valid = 1'b1; ex_rd = 5'd1; ex_reg_we = 1'b1; ex_is_load = 1'b0; ex_data = 32'h99;
        iv1 = 1'b1; ipc1 = 32'h200; iins1 = 32'h0020_8A33;
        @(negedge clk);
        chk("nobypass_in_ready", 32'(ir1), 32'd0);
        tick();
        ex_valid = 1'b0; ex_reg_we = 1'b0; ex_rd = 5'd0;
        // add x20,x1,x2: rd beyond NREGS
        send(1, 32'h200, 32'h0020_8A33, 1,
             mk(32'h200, 32'h11, 32'h55, 32'h0, 5'd20, ALU_ADD, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 1));
        // csrrw x1,0x300,x2 with CSR support disabled
        send(1, 32'h204, 32'h3001_10F3, 1,
             mk(32'h204, 32'h55, 32'h0, 32'h300, 5'd1, ALU_PASSB, 0, 1, 0, 0, 0, 1, 1, 1, 0, 1, 1));

        for (int n = 0; n < 20 && (q0.size() + q1.size()) != 0; n++) tick();
        chk("scoreboard_drained", 32'(q0.size() + q1.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/decode_read_stage.md
Name: decode_read_stage

Overview:
Parametrised decode/register-read pipeline stage for the RV32 core, successor to the fixed-width decode stage. It decodes one instruction per cycle and reads the register file with write-through and EX bypass. It detects load-use hazards and inserts bubbles itself. It drives a valid/ready registered output to the execute stage and supports flush and illegal-instruction flagging. It sits between fetch (upstream valid/ready) and execute.

Parameters:
XLEN, 32, datapath width; must be 32.
NREGS, 32, architectural register count; 32 for RV32I, 16 for RV32E. Index width is 5 bits.
BYPASS_EN, 1, 1 enables forwarding from the EX result port; 0 makes every EX-dependent read stall instead.
CSR_EN, 1, 1 decodes SYSTEM CSR ops; 0 flags them illegal.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  fetch presents instruction
in_ready  out  1  stage accepts instruction this cycle
in_pc  in  XLEN  instruction PC
in_instr  in  32  instruction word
flush  in  1  kill held and arriving instruction (branch/jump redirect)
out_valid  out  1  decoded bundle valid
out_ready  in  1  execute accepts bundle
out_pc  out  XLEN  registered PC
out_rs1_val, out_rs2_val  out  XLEN  operand values after bypass
out_rd, out_rs1, out_rs2  out  5  register indices
out_imm  out  XLEN  sign-extended immediate
out_alu_op  out  4  ALU opcode
out_a_sel, out_b_sel  out  1  0=rs1/rs2, 1=PC/imm
out_reg_we, out_mem_we, out_mem_re  out  1  control bits
out_funct3  out  3  funct3
out_csr, out_csr_imm  out  1  CSR op / CSR immediate form
out_illegal  out  1  instruction illegal
wb_we  in  1  writeback enable
wb_addr  in  5  writeback index
wb_data  in  XLEN  writeback data
ex_valid  in  1  EX holds a valid instruction
ex_rd  in  5  EX destination
ex_reg_we  in  1  EX writes a register
ex_is_load  in  1  EX instruction is a load (result not yet available)
ex_data  in  XLEN  EX ALU result

Behaviour:
- Interface: one clock, clk; reset, rst, is synchronous and active-high.
- Reset: out_valid=0. All out_* control bits, indices, imm and pc are 0. Register file contents are not reset, except x0, which always reads 0.
- Advance condition: adv = !out_valid | out_ready.
- Hazard condition: hz = ex_valid & ex_reg_we & ex_rd!=0 & (ex_rd==rs1_used | ex_rd==rs2_used) & (ex_is_load | !BYPASS_EN).
  - rs1_used and rs2_used come from the opcode; an operand the opcode does not read never hazards.
- in_ready = adv & !hz & !flush.
- Latency: 1 cycle from acceptance to out_valid.
- On adv with hz=1: load a bubble (out_valid=0) and hold the fetch instruction.
- Output stall: when out_valid & !out_ready, every out_* signal holds stable, including the operand values.
  - While held, an operand whose register matches a wb write with wb_we=1 is re-captured, so a held bundle never carries stale data.
- Flush: takes priority. Next cycle out_valid=0 and no instruction is accepted. Register file writes still occur.
- Operand priority, highest first:
  1. x0 reads 0.
  2. EX bypass: ex_valid & ex_reg_we & !ex_is_load & ex_rd match & BYPASS_EN.
  3. wb write-through: wb_we & wb_addr match.
  4. Register file array.
- Register file: 2 read ports, 1 write port. Writes with wb_addr==0 or wb_addr>=NREGS are ignored.
- Illegal when any of the following holds:
  - unknown opcode;
  - any used index >= NREGS;
  - a CSR op with CSR_EN=0.
- An illegal bundle is still delivered with out_illegal=1 and out_reg_we, out_mem_we, out_mem_re forced to 0.
- Immediates: I/S/B/U/J formats, sign-extended to XLEN.
- a_sel=1 for AUIPC, JAL and BRANCH.
- b_sel=0 only for R-type; b_sel=1 for every other opcode, including STORE.
- reg_we set for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP and CSR ops; it is cleared when rd==0.
- Simultaneous hz and out stall: the stall dominates and the bundle holds. hz is re-evaluated every cycle.

Decomposition:
- Shared package rv_pkg holds:
  - opcode constants OPC_*;
  - funct3 constants;
  - ALU op encodings;
  - immediate-format enum;
  - decoded-control struct type.
- One sub-module: rv_regfile (parameter NREGS, XLEN; 2R1W, x0 hardwired). Decode and bypass logic stay in the top module.

Test Plan:
- Reset then addi x1,x0,5 with out_ready=1 -> next cycle out_valid=1, out_imm=5, out_reg_we=1, out_rs1_val=0, out_illegal=0.
- wb writes x3=0xDEAD while add x4,x3,x3 is decoded in the same cycle -> out_rs1_val=out_rs2_val=0xDEAD (write-through).
- EX holds lw x5 (ex_is_load=1) while fetch presents add x6,x5,x1 -> in_ready=0 for 1 cycle and a bubble is issued. Then ex_is_load=0 and ex_data=7 with ex_rd=5 -> out_rs1_val=7.
- out_ready=0 for 3 cycles with a valid bundle -> all outputs stable. wb writes the bundle's rs2 register=0x55 during the hold -> out_rs2_val becomes 0x55 and nothing else changes.
- flush asserted while out_valid=1 and in_valid=1 -> next cycle out_valid=0, instruction not accepted (in_ready=0).
- NREGS=16: add x20,x1,x2 -> out_illegal=1 with reg_we, mem_we, mem_re all 0. CSR_EN=0 with csrrw -> out_illegal=1.
